// File: rtl/rvc_align_buffer.sv
// rvc_align_buffer
// Instruction alignment buffer between fetch and decode for an RV32IC core.
// Fetch delivers word-aligned 32-bit memory words. The buffer splits each word
// into halfwords, queues them, and presents one aligned instruction at a time.
// An instruction is either a 16-bit compressed one or a 32-bit one, and a
// 32-bit instruction may straddle two fetch words.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   flush        redirect: empties the queue and drops this cycle's fetch word
//   fetch_valid  fetch_word/fetch_pc are valid this cycle
//   fetch_word   memory word at {fetch_pc[31:2], 2'b00}
//   fetch_pc     address of the first wanted halfword (bit1=1 -> upper half only)
//   fetch_ready  room for a whole word (depends on registered state only)
//   id_valid     id_instr/id_pc/id_is_rvc hold a complete instruction
//   id_ready     decode accepts the presented instruction
//   id_instr     32-bit instruction, or {16'h0, halfword} when compressed
//   id_is_rvc    presented instruction is compressed
//   id_pc        address of id_instr
//
// Handshake: both interfaces are valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. Once id_valid is high, id_* stay
// stable until the transfer happens. fetch_ready never depends on id_ready,
// and fetch_valid is never required to stay high until accepted.

module rvc_align_buffer #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_word,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic        id_is_rvc,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int QW = 16 * QDEPTH;

  // Queue is a flat vector; halfword i lives at [16*i +: 16], entry 0 is the head.
  logic [QW-1:0]    q_q, q_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      head_pc_q, head_pc_d;

  logic [15:0]      head_hw;
  logic             head_rvc;
  logic             push_en;
  logic             pop_en;
  logic [1:0]       npush;
  logic [1:0]       npop;
  logic [QW+31:0]   shifted;
  int               remain;

  assign head_hw  = q_q[15:0];
  assign head_rvc = (head_hw[1:0] != 2'b11);

  assign fetch_ready = (count_q <= CW'(QDEPTH - 2));
  assign id_valid    = ((count_q >= CW'(1)) && head_rvc) ||
                       ((count_q >= CW'(2)) && !head_rvc);
  // Gate with a non-empty queue so an empty buffer shows all-zero outputs.
  assign id_is_rvc   = (count_q != '0) && head_rvc;
  assign id_instr    = (count_q == '0) ? 32'h0 :
                       head_rvc        ? {16'h0, head_hw} : q_q[31:0];
  assign id_pc       = head_pc_q;

  assign push_en = fetch_valid && fetch_ready && !flush;
  assign pop_en  = id_valid && id_ready && !flush;
  assign npush   = !push_en ? 2'd0 : (fetch_pc[1] ? 2'd1 : 2'd2);
  assign npop    = !pop_en  ? 2'd0 : (head_rvc    ? 2'd1 : 2'd2);

  always_comb begin
    // Drop popped halfwords off the head; zeros fill in behind.
    shifted   = {32'h0, q_q} >> {npop, 4'b0000};
    q_d       = shifted[QW-1:0];
    remain    = int'(count_q) - int'(npop);
    count_d   = count_q + CW'(npush) - CW'(npop);
    head_pc_d = head_pc_q + {29'h0, npop, 1'b0};

    // Pushed halfwords land right after whatever survives the pop.
    for (int i = 0; i < QDEPTH; i++) begin
      if ((npush != 2'd0) && (remain == i)) begin
        q_d[16*i +: 16] = fetch_pc[1] ? fetch_word[31:16] : fetch_word[15:0];
      end
      if ((npush == 2'd2) && (remain + 1 == i)) begin
        q_d[16*i +: 16] = fetch_word[31:16];
      end
    end

    // A push into a queue that is empty after the pop restarts the PC.
    if ((npush != 2'd0) && (remain == 0)) begin
      head_pc_d = fetch_pc;
    end

    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
    end else begin
      q_q       <= q_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
    end
  end

endmodule

// File: tb/tb_rvc_align_buffer.sv
module tb_rvc_align_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_word;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic        id_is_rvc;
  logic [31:0] id_pc;

  // Expected entry: {pc[31:0], instr[31:0], is_rvc}
  logic [64:0] exp_q[$];
  logic [15:0] hw_q[$];
  int          n_vec;
  int          n_err;
  int          cyc;
  bit          rand_ready_on;

  rvc_align_buffer #(.QDEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fetch_valid(fetch_valid),
    .fetch_word (fetch_word),
    .fetch_pc   (fetch_pc),
    .fetch_ready(fetch_ready),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_is_rvc  (id_is_rvc),
    .id_pc      (id_pc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a transfer happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!reset && !flush && id_valid && id_ready) begin
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_out: got pc=%h instr=%h rvc=%0b, expected nothing", id_pc, id_instr, id_is_rvc);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({id_pc, id_instr, id_is_rvc} !== e) begin
          n_err = n_err + 1;
          $display("FAIL sb_out: got pc=%h instr=%h rvc=%0b, expected pc=%h instr=%h rvc=%0b",
                   id_pc, id_instr, id_is_rvc, e[64:33], e[32:1], e[0]);
        end
      end
    end
  end

  // Random id_ready generator for the stress scenario.
  always @(posedge clk) begin
    if (rand_ready_on) begin
      #1 id_ready = 1'($urandom_range(0, 1));
    end
  end

  // Driver tasks (called right after a rising edge)
  task automatic send_word(input logic [31:0] w, input logic [31:0] pc);
    bit acc;
    int k;
    acc = 1'b0;
    k   = 0;
    fetch_valid = 1'b1;
    fetch_word  = w;
    fetch_pc    = pc;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = fetch_ready;
      @(posedge clk);
      #1;
      k++;
    end
    fetch_valid = 1'b0;
    n_vec = n_vec + 1;
    if (!acc) begin
      n_err = n_err + 1;
      $display("FAIL send_word: word %h @%h not accepted within 50 cycles, expected accept", w, pc);
    end
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_vec = n_vec + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: %0d instrs still pending after %0d cycles, expected 0", exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  // Reference stream model: random instructions laid out as a halfword image.
  task automatic gen_stream(input logic [31:0] pc0, input int n, input bit all32);
    logic [31:0] pc;
    logic [31:0] w;
    logic [15:0] h;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      if (!all32 && $urandom_range(0, 1) == 1) begin
        h = 16'($urandom);
        h[1:0] = 2'($urandom_range(0, 2));
        exp_q.push_back({pc, 16'h0, h, 1'b1});
        hw_q.push_back(h);
        pc = pc + 32'd2;
      end else begin
        w = $urandom;
        w[1:0] = 2'b11;
        exp_q.push_back({pc, w, 1'b0});
        hw_q.push_back(w[15:0]);
        hw_q.push_back(w[31:16]);
        pc = pc + 32'd4;
      end
    end
    if (hw_q.size() % 2 == 1) begin
      exp_q.push_back({pc, 32'h0000_0001, 1'b1});
      hw_q.push_back(16'h0001);
    end
  endtask

  task automatic send_stream(input logic [31:0] pc0, input int max_words);
    logic [31:0] pc;
    int k;
    pc = pc0;
    k  = 0;
    while (hw_q.size() >= 2 && k < max_words) begin
      send_word({hw_q[1], hw_q[0]}, pc);
      void'(hw_q.pop_front());
      void'(hw_q.pop_front());
      pc = pc + 32'd4;
      k++;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec = n_vec + 5;
    if (id_valid !== 1'b0)    begin n_err++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    if (id_instr !== 32'h0)   begin n_err++; $display("FAIL reset_id_instr: got %h expected 00000000", id_instr); end
    if (id_pc !== 32'h0)      begin n_err++; $display("FAIL reset_id_pc: got %h expected 00000000", id_pc); end
    if (id_is_rvc !== 1'b0)   begin n_err++; $display("FAIL reset_id_is_rvc: got %b expected 0", id_is_rvc); end
    if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL reset_fetch_ready: got %b expected 1", fetch_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single32();
    id_ready = 1'b1;
    exp_q.push_back({32'h0, 32'h00A0_0513, 1'b0});
    send_word(32'h00A0_0513, 32'h0);
    // One cycle after acceptance the instruction must already be presented.
    n_vec = n_vec + 1;
    if ({id_valid, id_instr, id_pc, id_is_rvc} !== {1'b1, 32'h00A0_0513, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL latency: got v=%b instr=%h pc=%h rvc=%b expected v=1 instr=00a00513 pc=0 rvc=0",
               id_valid, id_instr, id_pc, id_is_rvc);
    end
    wait_drain(10);
  endtask

  task automatic test_two_rvc();
    id_ready = 1'b1;
    exp_q.push_back({32'h4, 32'h0000_4501, 1'b1});
    exp_q.push_back({32'h6, 32'h0000_4505, 1'b1});
    send_word(32'h4505_4501, 32'h4);
    wait_drain(10);
  endtask

  task automatic test_straddle();
    id_ready = 1'b1;
    exp_q.push_back({32'h8, 32'h0000_4501, 1'b1});
    exp_q.push_back({32'hA, 32'h00A0_0513, 1'b0});
    exp_q.push_back({32'hE, 32'h0000_0000, 1'b1});
    send_word(32'h0513_4501, 32'h8);
    repeat (3) @(posedge clk);
    #1;
    n_vec = n_vec + 1;
    if (id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL straddle_hold: got id_valid=%b expected 0", id_valid);
    end
    send_word(32'h0000_00A0, 32'hC);
    wait_drain(10);
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    send_word(32'h0513_4501, 32'h10);   // stale content, never emitted
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_word  = 32'h1111_1111;        // same-cycle word must be dropped
    fetch_pc    = 32'h20;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    @(negedge clk);
    n_vec = n_vec + 2;
    if (id_valid !== 1'b0)    begin n_err++; $display("FAIL flush_valid: got %b expected 0", id_valid); end
    if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b expected 1", fetch_ready); end
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    exp_q.push_back({32'h12, 32'h0000_4501, 1'b1});
    send_word(32'h4501_0000, 32'h12);
    wait_drain(10);
  endtask

  task automatic test_backpressure();
    logic [31:0] cap_instr;
    logic [31:0] cap_pc;
    id_ready = 1'b0;
    gen_stream(32'h100, 10, 1'b0);
    send_stream(32'h100, 2);            // fills all four entries
    @(negedge clk);
    cap_instr = id_instr;
    cap_pc    = id_pc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec = n_vec + 3;
      if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, fetch_ready); end
      if (id_valid !== 1'b1)    begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, id_valid); end
      if ({id_instr, id_pc} !== {cap_instr, cap_pc}) begin
        n_err++;
        $display("FAIL bp_stable[%0d]: got instr=%h pc=%h expected instr=%h pc=%h", i, id_instr, id_pc, cap_instr, cap_pc);
      end
    end
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    send_stream(32'h108, 100);
    wait_drain(40);
  endtask

  task automatic test_back_to_back();
    int t0;
    int dt;
    id_ready = 1'b1;
    gen_stream(32'h300, 8, 1'b1);
    t0 = cyc;
    send_stream(32'h300, 100);
    wait_drain(20);
    dt = cyc - t0;
    n_vec = n_vec + 1;
    if (dt > 11) begin
      n_err++;
      $display("FAIL throughput: 8 x 32-bit took %0d cycles, expected <= 11", dt);
    end
  endtask

  task automatic test_random_ready();
    gen_stream(32'h200, 40, 1'b0);
    rand_ready_on = 1'b1;
    send_stream(32'h200, 100);
    wait_drain(200);
    rand_ready_on = 1'b0;
    @(posedge clk);
    #1 id_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b1;
    exp_q.push_back({32'h30, 32'h0000_4501, 1'b1});
    send_word(32'h0513_4501, 32'h30);
    repeat (2) @(posedge clk);
    #1;
    n_vec = n_vec + 1;
    if (id_valid !== 1'b0) begin n_err++; $display("FAIL mid_partial: got id_valid=%b expected 0", id_valid); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec = n_vec + 3;
    if (id_valid !== 1'b0)    begin n_err++; $display("FAIL mid_reset_valid: got %b expected 0", id_valid); end
    if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready: got %b expected 1", fetch_ready); end
    if (id_pc !== 32'h0)      begin n_err++; $display("FAIL mid_reset_pc: got %h expected 00000000", id_pc); end
    @(posedge clk);
    #1;
    exp_q.push_back({32'h40, 32'h00A0_0513, 1'b0});
    send_word(32'h00A0_0513, 32'h40);
    wait_drain(10);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    cyc           = 0;
    rand_ready_on = 1'b0;
    reset         = 1'b1;
    flush         = 1'b0;
    fetch_valid   = 1'b0;
    fetch_word    = 32'h0;
    fetch_pc      = 32'h0;
    id_ready      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single32();
    test_two_rvc();
    test_straddle();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_random_ready();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
